dtu_word_serializer: RTL and testbench

//  Transmit-side counterpart of the LiTe-DTU 4-lane serial link decoder: takes 32-bit frame words
//  (baseline/signal/header/trailer) for 4 lanes via valid/ready, shifts them out MSB-first, 1 bit/clk.

---
 rtl/dtu_word_serializer.sv | 124 ++++++++++++
 tb/tb_dtu_word_serializer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dtu_word_serializer.sv
// Transmit side of the LiTe-DTU 4-lane link: shifts 32-bit frame words out MSB-first, one bit per clock,
// preceded by a SYNC sequence after reset/resync and padded with IDLE (or TEST) words when no data is offered.
module dtu_word_serializer #(
    parameter logic [31:0] SYNC_WORD  = 32'h355AA55A,
    parameter logic [31:0] IDLE_WORD  = 32'hEAAAAAAA,
    parameter logic [31:0] TEST_WORD  = 32'h5A5A5A5A,
    parameter int unsigned SYNC_WORDS = 4
) (
    input  logic        clk_srl,
    input  logic        rst,
    input  logic        test_enable,
    input  logic        resync,
    input  logic [31:0] word_in_0,
    input  logic [31:0] word_in_1,
    input  logic [31:0] word_in_2,
    input  logic [31:0] word_in_3,
    input  logic        word_valid,
    output logic        word_ready,
    output logic        output_ser_0,
    output logic        output_ser_1,
    output logic        output_ser_2,
    output logic        output_ser_3,
    output logic        sync_busy,
    output logic [15:0] data_word_cnt,
    output logic [15:0] idle_word_cnt
);

    localparam logic [3:0] SYNC_N  = 4'(SYNC_WORDS);
    localparam logic [0:0] ST_SYNC = 1'b0;
    localparam logic [0:0] ST_DATA = 1'b1;

    logic [31:0] r_shift_0;
    logic [31:0] r_shift_1;
    logic [31:0] r_shift_2;
    logic [31:0] r_shift_3;
    logic [4:0]  r_bit_cnt;
    logic [3:0]  r_sync_cnt;
    logic [0:0]  r_state;
    logic        r_resync_pend;
    logic [15:0] r_data_cnt;
    logic [15:0] r_idle_cnt;

    logic        w_boundary;
    logic        w_data_slot;
    logic        w_resync_req;
    logic [31:0] w_sync_fill;
    logic [31:0] w_idle_fill;

    assign w_boundary   = (r_bit_cnt == 5'd31);
    // The last SYNC word's closing boundary already behaves as a DATA boundary.
    assign w_data_slot  = (r_state == ST_DATA) | (r_sync_cnt == SYNC_N);
    assign w_resync_req = r_resync_pend | resync;
    assign w_sync_fill  = test_enable ? TEST_WORD : SYNC_WORD;
    assign w_idle_fill  = test_enable ? TEST_WORD : IDLE_WORD;

    assign word_ready = w_boundary & ~rst & ~w_resync_req & w_data_slot;

    always_ff @(posedge clk_srl) begin
        if (rst) begin
            r_shift_0     <= '0;
            r_shift_1     <= '0;
            r_shift_2     <= '0;
            r_shift_3     <= '0;
            r_bit_cnt     <= 5'd31;
            r_sync_cnt    <= '0;
            r_state       <= ST_SYNC;
            r_resync_pend <= 1'b0;
            r_data_cnt    <= '0;
            r_idle_cnt    <= '0;
        end else if (!w_boundary) begin
            r_shift_0 <= {r_shift_0[30:0], 1'b0};
            r_shift_1 <= {r_shift_1[30:0], 1'b0};
            r_shift_2 <= {r_shift_2[30:0], 1'b0};
            r_shift_3 <= {r_shift_3[30:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (resync && (r_state == ST_DATA)) begin
                r_resync_pend <= 1'b1;
            end
        end else begin
            r_bit_cnt <= 5'd0;
            if (!w_data_slot) begin
                r_shift_0  <= w_sync_fill;
                r_shift_1  <= w_sync_fill;
                r_shift_2  <= w_sync_fill;
                r_shift_3  <= w_sync_fill;
                r_sync_cnt <= r_sync_cnt + 4'd1;
            end else if (w_resync_req) begin
                r_state       <= ST_SYNC;
                r_sync_cnt    <= 4'd1;
                r_resync_pend <= 1'b0;
                r_shift_0     <= w_sync_fill;
                r_shift_1     <= w_sync_fill;
                r_shift_2     <= w_sync_fill;
                r_shift_3     <= w_sync_fill;
            end else begin
                r_state <= ST_DATA;
                if (word_valid) begin
                    r_shift_0  <= word_in_0;
                    r_shift_1  <= word_in_1;
                    r_shift_2  <= word_in_2;
                    r_shift_3  <= word_in_3;
                    r_data_cnt <= r_data_cnt + 16'd1;
                end else begin
                    r_shift_0 <= w_idle_fill;
                    r_shift_1 <= w_idle_fill;
                    r_shift_2 <= w_idle_fill;
                    r_shift_3 <= w_idle_fill;
                    if (r_idle_cnt != 16'hFFFF) begin
                        r_idle_cnt <= r_idle_cnt + 16'd1;
                    end
                end
            end
        end
    end

    assign output_ser_0  = r_shift_0[31];
    assign output_ser_1  = r_shift_1[31];
    assign output_ser_2  = r_shift_2[31];
    assign output_ser_3  = r_shift_3[31];
    assign sync_busy     = (r_state == ST_SYNC);
    assign data_word_cnt = r_data_cnt;
    assign idle_word_cnt = r_idle_cnt;

endmodule

// File: tb/tb_dtu_word_serializer.sv
// Bench for dtu_word_serializer: stimulus queues the expected 4-lane word for every 32-bit slot,
// a monitor deserialises the lanes and compares each completed word against the queue head.
module tb_dtu_word_serializer;

    localparam logic [31:0] SYNC_W = 32'h355AA55A;
    localparam logic [31:0] IDLE_W = 32'hEAAAAAAA;
    localparam logic [31:0] TEST_W = 32'h5A5A5A5A;
    localparam logic [127:0] SYNC4 = {SYNC_W, SYNC_W, SYNC_W, SYNC_W};
    localparam logic [127:0] IDLE4 = {IDLE_W, IDLE_W, IDLE_W, IDLE_W};
    localparam logic [127:0] TEST4 = {TEST_W, TEST_W, TEST_W, TEST_W};

    logic        clk_srl = 1'b0;
    logic        rst = 1'b1;
    logic        test_enable = 1'b0;
    logic        resync = 1'b0;
    logic [31:0] word_in_0 = '0;
    logic [31:0] word_in_1 = '0;
    logic [31:0] word_in_2 = '0;
    logic [31:0] word_in_3 = '0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic        output_ser_0;
    logic        output_ser_1;
    logic        output_ser_2;
    logic        output_ser_3;
    logic        sync_busy;
    logic [15:0] data_word_cnt;
    logic [15:0] idle_word_cnt;

    int n_checks = 0;
    int n_errs   = 0;
    logic [127:0] exp_q[$];
    bit mon_en = 1'b1;

    always #5 clk_srl = ~clk_srl;

    dtu_word_serializer dut (
        .clk_srl       (clk_srl),
        .rst           (rst),
        .test_enable   (test_enable),
        .resync        (resync),
        .word_in_0     (word_in_0),
        .word_in_1     (word_in_1),
        .word_in_2     (word_in_2),
        .word_in_3     (word_in_3),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .output_ser_0  (output_ser_0),
        .output_ser_1  (output_ser_1),
        .output_ser_2  (output_ser_2),
        .output_ser_3  (output_ser_3),
        .sync_busy     (sync_busy),
        .data_word_cnt (data_word_cnt),
        .idle_word_cnt (idle_word_cnt)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: one word per 32 samples, realigned whenever reset is seen.
    initial begin
        logic [31:0] sh0, sh1, sh2, sh3;
        int mcnt;
        logic [127:0] e;
        mcnt = 0;
        forever begin
            @(negedge clk_srl);
            if (rst) begin
                mcnt = 0;
            end else begin
                sh0 = {sh0[30:0], output_ser_0};
                sh1 = {sh1[30:0], output_ser_1};
                sh2 = {sh2[30:0], output_ser_2};
                sh3 = {sh3[30:0], output_ser_3};
                mcnt++;
                if (mcnt == 32) begin
                    mcnt = 0;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("lane words", {sh0, sh1, sh2, sh3}, e);
                    end else if (mon_en) begin
                        chk("unexpected word", {sh0, sh1, sh2, sh3}, 128'hX);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        repeat (4) begin
            @(negedge clk_srl);
            #1;
        end
        rst = 1'b0;
    endtask

    // One 32-clock slot starting just before a boundary edge.
    task automatic slot(input bit v, input logic [127:0] d, input logic [127:0] e,
                        input bit rdy, input bit hold, input int rs_at, input string nm);
        word_valid = v;
        {word_in_0, word_in_1, word_in_2, word_in_3} = d;
        exp_q.push_back(e);
        #1;
        chk({nm, " ready"}, 128'(word_ready), 128'(rdy));
        for (int c = 0; c < 32; c++) begin
            @(negedge clk_srl);
            #1;
            if (c == 0 && !hold) word_valid = 1'b0;
            resync = (c == rs_at);
        end
        resync = 1'b0;
    endtask

    task automatic chk_cnt(input string nm, input logic [15:0] d, input logic [15:0] i, input bit busy);
        chk({nm, " data_cnt"}, 128'(data_word_cnt), 128'(d));
        chk({nm, " idle_cnt"}, 128'(idle_word_cnt), 128'(i));
        chk({nm, " sync_busy"}, 128'(sync_busy), 128'(busy));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-up sync sequence, then idle fill
        do_reset();
        for (int i = 0; i < 4; i++) slot(0, '0, SYNC4, 0, 0, -1, "t1 sync");
        chk("t1 busy before data", 128'(sync_busy), 128'(1));
        slot(0, '0, IDLE4, 1, 0, -1, "t1 idle");
        slot(0, '0, IDLE4, 1, 0, -1, "t1 idle");
        chk_cnt("t1", 16'd0, 16'd2, 1'b0);

        // Reset state, header word at the first data slot
        do_reset();
        chk("t2 reset outputs", 128'({output_ser_0, output_ser_1, output_ser_2, output_ser_3}), 128'(0));
        chk("t2 reset ready", 128'(word_ready), 128'(0));
        chk_cnt("t2 reset", 16'd0, 16'd0, 1'b1);
        for (int i = 0; i < 4; i++) slot(0, '0, SYNC4, 0, 0, -1, "t2 sync");
        slot(1, {32'h2B000ABC, 32'h11223344, 32'h55667788, 32'h99AABBCC},
             {32'h2B000ABC, 32'h11223344, 32'h55667788, 32'h99AABBCC}, 1, 0, -1, "t2 header");
        chk_cnt("t2", 16'd1, 16'd0, 1'b0);

        // Back-to-back signal words
        slot(1, {32'h28000101, 32'h28000202, 32'h28000303, 32'h28000404},
             {32'h28000101, 32'h28000202, 32'h28000303, 32'h28000404}, 1, 0, -1, "t3 sig a");
        slot(1, {32'h28FFFF00, 32'h28123456, 32'h28ABCDEF, 32'h28000001},
             {32'h28FFFF00, 32'h28123456, 32'h28ABCDEF, 32'h28000001}, 1, 0, -1, "t3 sig b");
        slot(1, {32'h28800000, 32'h28400000, 32'h28200000, 32'h28100000},
             {32'h28800000, 32'h28400000, 32'h28200000, 32'h28100000}, 1, 0, -1, "t3 sig c");
        chk_cnt("t3", 16'd4, 16'd0, 1'b0);

        // Resync mid-word: word completes, then four SYNC words with valid held
        slot(1, {32'h2A000001, 32'h2A000002, 32'h2A000003, 32'h2A000004},
             {32'h2A000001, 32'h2A000002, 32'h2A000003, 32'h2A000004}, 1, 0, 10, "t4 word");
        for (int i = 0; i < 4; i++)
            slot(1, {32'h29000077, 32'h29000088, 32'h29000099, 32'h290000AA}, SYNC4, 0, 1, -1, "t4 sync");
        chk_cnt("t4 held", 16'd5, 16'd0, 1'b1);
        slot(1, {32'h29000077, 32'h29000088, 32'h29000099, 32'h290000AA},
             {32'h29000077, 32'h29000088, 32'h29000099, 32'h290000AA}, 1, 0, -1, "t4 accept");
        chk_cnt("t4", 16'd6, 16'd0, 1'b0);

        // Test mode fill; data words pass untouched
        test_enable = 1'b1;
        slot(0, '0, TEST4, 1, 0, -1, "t5 test fill");
        slot(1, {32'h2C001234, 32'h2C005678, 32'hE0000000, 32'h35000000},
             {32'h2C001234, 32'h2C005678, 32'hE0000000, 32'h35000000}, 1, 0, -1, "t5 data");
        test_enable = 1'b0;
        chk_cnt("t5", 16'd7, 16'd1, 1'b0);

        // Reset mid-word at bit 17, then idle counter saturation
        word_valid = 1'b0;
        for (int c = 0; c <= 17; c++) begin
            @(negedge clk_srl);
            #1;
        end
        rst = 1'b1;
        @(negedge clk_srl);
        #1;
        chk("t6 outputs", 128'({output_ser_0, output_ser_1, output_ser_2, output_ser_3}), 128'(0));
        chk("t6 ready", 128'(word_ready), 128'(0));
        chk_cnt("t6 reset", 16'd0, 16'd0, 1'b1);
        repeat (3) begin
            @(negedge clk_srl);
            #1;
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) slot(0, '0, SYNC4, 0, 0, -1, "t6 sync");
        slot(0, '0, IDLE4, 1, 0, -1, "t6 idle");
        chk_cnt("t6 idle", 16'd0, 16'd1, 1'b0);
        force dut.r_idle_cnt = 16'hFFFE;
        #1;
        release dut.r_idle_cnt;
        slot(0, '0, IDLE4, 1, 0, -1, "t6 sat a");
        chk("t6 idle ffff", 128'(idle_word_cnt), 128'(16'hFFFF));
        slot(0, '0, IDLE4, 1, 0, -1, "t6 sat b");
        chk("t6 idle hold", 128'(idle_word_cnt), 128'(16'hFFFF));

        mon_en = 1'b0;
        chk("queue drained", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
